// File: rtl/fc_layer_sequencer_pkg.sv
// Shared types and constants for the fully-connected layer sequencer.
package fc_pkg;

  localparam int MAX_LAYERS = 8;

  localparam logic [1:0] ALULOAD_VALUES       = 2'd0;
  localparam logic [1:0] ALULOAD_BIAS_WEIGHTS = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_FINISH,
    ST_SOFTMAX,
    ST_DONE
  } fc_state_e;

  // Bus code that selects the DMA stream: all ones in the low 'width' bits.
  function automatic logic [7:0] bus_sel_dma(input int width);
    logic [7:0] code;
    code = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < width) code[i] = 1'b1;
    end
    return code;
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_addr_gen.sv
// Per-layer bias/weight address generator: holds base and stride (in_size+1)
// for each layer and walks the burst start address neuron by neuron.
module fc_addr_gen
  import fc_pkg::*;
#(
  parameter int MEM_ADDRESS_WIDTH   = 10,
  parameter int LAYER_ADDRESS_WIDTH = 7,
  parameter int NUM_LAYERS          = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clk_en,
  input  logic                                      cfg_latch,
  input  logic [NUM_LAYERS*LAYER_ADDRESS_WIDTH-1:0] cfg_in_size,
  input  logic [NUM_LAYERS*MEM_ADDRESS_WIDTH-1:0]   cfg_base_addr,
  input  logic [2:0]                                layer_sel,
  input  logic                                      addr_load,
  input  logic                                      addr_adv,
  output logic [MEM_ADDRESS_WIDTH-1:0]              addr_next,
  output logic [LAYER_ADDRESS_WIDTH:0]              stride
);

  localparam int MAW = MEM_ADDRESS_WIDTH;
  localparam int LAW = LAYER_ADDRESS_WIDTH;

  logic [MAW-1:0] base_q   [MAX_LAYERS];
  logic [MAW-1:0] base_d   [MAX_LAYERS];
  logic [LAW:0]   stride_q [MAX_LAYERS];
  logic [LAW:0]   stride_d [MAX_LAYERS];
  logic [MAW-1:0] addr_q;
  logic [MAW-1:0] addr_d;

  always_comb begin
    base_d   = base_q;
    stride_d = stride_q;
    if (cfg_latch) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        base_d[i]   = cfg_base_addr[i*MAW +: MAW];
        stride_d[i] = (LAW+1)'(cfg_in_size[i*LAW +: LAW]) + (LAW+1)'(1);
      end
    end
  end

  // Address wraps modulo 2^MAW by plain truncation.
  always_comb begin
    addr_d = addr_q;
    if (addr_load)     addr_d = base_q[layer_sel];
    else if (addr_adv) addr_d = addr_q + MAW'(stride_q[layer_sel]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
    end else if (clk_en) begin
      addr_q <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      base_q   <= base_d;
      stride_q <= stride_d;
    end
  end

  assign addr_next = addr_d;
  assign stride    = stride_q[layer_sel];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Dense-layer sequencer: per neuron issues a bias+weight DMA burst, steers bus/ALU
// and writes the neuron buffer. Define FC_SOFTMAX_EN to add the softmax stage.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int MEM_ADDRESS_WIDTH   = 10,
  parameter int LAYER_ADDRESS_WIDTH = 7,
  parameter int NUM_LAYERS          = 2,
  parameter int BUS_SEL_W           = $clog2(NUM_LAYERS + 2)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clk_en,
  input  logic                                      CNN_ready,
  input  logic [NUM_LAYERS*LAYER_ADDRESS_WIDTH-1:0] cfg_in_size,
  input  logic [NUM_LAYERS*LAYER_ADDRESS_WIDTH-1:0] cfg_out_size,
  input  logic [NUM_LAYERS*MEM_ADDRESS_WIDTH-1:0]   cfg_base_addr,
  output logic                                      DMA_read,
  output logic [MEM_ADDRESS_WIDTH-1:0]              DMA_address,
  output logic [LAYER_ADDRESS_WIDTH:0]              DMA_count,
  input  logic                                      DMA_ready,
  output logic                                      ALU_clear,
  output logic                                      ALU_en,
  output logic [1:0]                                ALU_load,
  output logic [BUS_SEL_W-1:0]                      Bus_datasrc,
  output logic                                      Neuron_wr,
  output logic [2:0]                                Neuron_layer,
  output logic [LAYER_ADDRESS_WIDTH-1:0]            Neuron_address,
`ifdef FC_SOFTMAX_EN
  output logic                                      softmax_start,
  input  logic                                      softmax_done,
`endif
  output logic                                      done
);

  localparam int MAW = MEM_ADDRESS_WIDTH;
  localparam int LAW = LAYER_ADDRESS_WIDTH;
  localparam logic [BUS_SEL_W-1:0] BUS_DMA    = BUS_SEL_W'(bus_sel_dma(BUS_SEL_W));
  localparam logic [BUS_SEL_W-1:0] BUS_FINAL  = BUS_SEL_W'(NUM_LAYERS);
  localparam logic [2:0]           LAST_LAYER = 3'(NUM_LAYERS - 1);

  fc_state_e state_q, state_d;
  logic [2:0]           l_q, l_d;
  logic [LAW-1:0]       n_q, n_d;
  logic [LAW-1:0]       out_size_q [MAX_LAYERS];
  logic [LAW-1:0]       out_size_d [MAX_LAYERS];

  logic                 dma_read_q, dma_read_d;
  logic [MAW-1:0]       dma_address_q, dma_address_d;
  logic [LAW:0]         dma_count_q, dma_count_d;
  logic                 alu_clear_q, alu_clear_d;
  logic                 alu_en_q, alu_en_d;
  logic [1:0]           alu_load_q, alu_load_d;
  logic [BUS_SEL_W-1:0] bus_sel_q, bus_sel_d;
  logic                 neuron_wr_q, neuron_wr_d;
  logic [2:0]           neuron_layer_q, neuron_layer_d;
  logic [LAW-1:0]       neuron_address_q, neuron_address_d;
  logic                 done_q, done_d;
`ifdef FC_SOFTMAX_EN
  logic                 softmax_start_q, softmax_start_d;
`endif

  logic           cfg_latch, addr_load, addr_adv;
  logic [MAW-1:0] addr_next;
  logic [LAW:0]   stride;
  logic [LAW-1:0] cur_out_size;
  logic           last_neuron, last_layer;

  fc_addr_gen #(
    .MEM_ADDRESS_WIDTH  (MEM_ADDRESS_WIDTH),
    .LAYER_ADDRESS_WIDTH(LAYER_ADDRESS_WIDTH),
    .NUM_LAYERS         (NUM_LAYERS)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .cfg_latch    (cfg_latch),
    .cfg_in_size  (cfg_in_size),
    .cfg_base_addr(cfg_base_addr),
    .layer_sel    (l_q),
    .addr_load    (addr_load),
    .addr_adv     (addr_adv),
    .addr_next    (addr_next),
    .stride       (stride)
  );

  assign cur_out_size = out_size_q[l_q];
  assign last_neuron  = ((LAW+1)'(n_q) + (LAW+1)'(1)) == (LAW+1)'(cur_out_size);
  assign last_layer   = (l_q == LAST_LAYER);

  // Layer sizes are captured once per run so cfg edits mid-run are invisible.
  always_comb begin
    out_size_d = out_size_q;
    if (state_q == ST_IDLE && CNN_ready) begin
      for (int i = 0; i < NUM_LAYERS; i++) out_size_d[i] = cfg_out_size[i*LAW +: LAW];
    end
  end

  always_comb begin
    state_d          = state_q;
    l_d              = l_q;
    n_d              = n_q;
    dma_read_d       = 1'b0;
    alu_clear_d      = 1'b0;
    alu_en_d         = 1'b0;
    neuron_wr_d      = 1'b0;
    dma_address_d    = dma_address_q;
    dma_count_d      = dma_count_q;
    alu_load_d       = alu_load_q;
    bus_sel_d        = bus_sel_q;
    neuron_layer_d   = neuron_layer_q;
    neuron_address_d = neuron_address_q;
    done_d           = done_q;
`ifdef FC_SOFTMAX_EN
    softmax_start_d  = 1'b0;
`endif
    cfg_latch        = 1'b0;
    addr_load        = 1'b0;
    addr_adv         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CNN_ready) begin
          cfg_latch   = 1'b1;
          l_d         = '0;
          n_d         = '0;
          alu_clear_d = 1'b1;
          alu_load_d  = ALULOAD_VALUES;
          bus_sel_d   = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cur_out_size == '0) begin
          if (last_layer) begin
            state_d = ST_FINISH;
          end else begin
            l_d         = l_q + 3'd1;
            bus_sel_d   = BUS_SEL_W'(l_q + 3'd1);
            alu_clear_d = 1'b1;
          end
        end else begin
          addr_load     = 1'b1;
          dma_read_d    = 1'b1;
          dma_address_d = addr_next;
          dma_count_d   = stride;
          bus_sel_d     = BUS_DMA;
          alu_load_d    = ALULOAD_BIAS_WEIGHTS;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (DMA_ready) begin
          alu_en_d         = 1'b1;
          neuron_wr_d      = 1'b1;
          neuron_layer_d   = l_q;
          neuron_address_d = n_q;
          alu_clear_d      = !last_neuron;
          state_d          = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!last_neuron) begin
          n_d           = n_q + 1'b1;
          addr_adv      = 1'b1;
          dma_read_d    = 1'b1;
          dma_address_d = addr_next;
          dma_count_d   = stride;
          state_d       = ST_REQ;
        end else if (!last_layer) begin
          l_d         = l_q + 3'd1;
          n_d         = '0;
          alu_clear_d = 1'b1;
          alu_load_d  = ALULOAD_VALUES;
          bus_sel_d   = BUS_SEL_W'(l_q + 3'd1);
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        bus_sel_d = BUS_FINAL;
`ifdef FC_SOFTMAX_EN
        softmax_start_d = 1'b1;
        state_d         = ST_SOFTMAX;
`else
        done_d  = 1'b1;
        state_d = ST_DONE;
`endif
      end
      ST_SOFTMAX: begin
`ifdef FC_SOFTMAX_EN
        if (softmax_done) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (!CNN_ready) begin
          done_d           = 1'b0;
          dma_address_d    = '0;
          dma_count_d      = '0;
          alu_load_d       = '0;
          bus_sel_d        = '0;
          neuron_layer_d   = '0;
          neuron_address_d = '0;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      l_q              <= '0;
      n_q              <= '0;
      dma_read_q       <= 1'b0;
      dma_address_q    <= '0;
      dma_count_q      <= '0;
      alu_clear_q      <= 1'b0;
      alu_en_q         <= 1'b0;
      alu_load_q       <= '0;
      bus_sel_q        <= '0;
      neuron_wr_q      <= 1'b0;
      neuron_layer_q   <= '0;
      neuron_address_q <= '0;
      done_q           <= 1'b0;
`ifdef FC_SOFTMAX_EN
      softmax_start_q  <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q          <= state_d;
      l_q              <= l_d;
      n_q              <= n_d;
      dma_read_q       <= dma_read_d;
      dma_address_q    <= dma_address_d;
      dma_count_q      <= dma_count_d;
      alu_clear_q      <= alu_clear_d;
      alu_en_q         <= alu_en_d;
      alu_load_q       <= alu_load_d;
      bus_sel_q        <= bus_sel_d;
      neuron_wr_q      <= neuron_wr_d;
      neuron_layer_q   <= neuron_layer_d;
      neuron_address_q <= neuron_address_d;
      done_q           <= done_d;
`ifdef FC_SOFTMAX_EN
      softmax_start_q  <= softmax_start_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) out_size_q <= out_size_d;
  end

  assign DMA_read       = dma_read_q;
  assign DMA_address    = dma_address_q;
  assign DMA_count      = dma_count_q;
  assign ALU_clear      = alu_clear_q;
  assign ALU_en         = alu_en_q;
  assign ALU_load       = alu_load_q;
  assign Bus_datasrc    = bus_sel_q;
  assign Neuron_wr      = neuron_wr_q;
  assign Neuron_layer   = neuron_layer_q;
  assign Neuron_address = neuron_address_q;
  assign done           = done_q;
`ifdef FC_SOFTMAX_EN
  assign softmax_start  = softmax_start_q;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: expected DMA bursts and neuron writes
// are queued when a run starts and popped as the DUT strobes them.
`timescale 1ns/1ps
module tb_fc_layer_sequencer;
  localparam int MAW = 10;
  localparam int LAW = 7;
  localparam int NL  = 2;
  localparam int BSW = $clog2(NL + 2);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clk_en = 1'b1;
  logic              CNN_ready = 1'b0;
  logic [NL*LAW-1:0] cfg_in_size = '0;
  logic [NL*LAW-1:0] cfg_out_size = '0;
  logic [NL*MAW-1:0] cfg_base_addr = '0;
  logic              DMA_read;
  logic [MAW-1:0]    DMA_address;
  logic [LAW:0]      DMA_count;
  logic              DMA_ready = 1'b0;
  logic              ALU_clear, ALU_en, Neuron_wr, done;
  logic [1:0]        ALU_load;
  logic [BSW-1:0]    Bus_datasrc;
  logic [2:0]        Neuron_layer;
  logic [LAW-1:0]    Neuron_address;
`ifdef FC_SOFTMAX_EN
  logic              softmax_start;
  logic              softmax_done = 1'b0;
  int                sm_set_cyc = 0;
`endif

  fc_layer_sequencer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .CNN_ready(CNN_ready),
    .cfg_in_size(cfg_in_size), .cfg_out_size(cfg_out_size), .cfg_base_addr(cfg_base_addr),
    .DMA_read(DMA_read), .DMA_address(DMA_address), .DMA_count(DMA_count), .DMA_ready(DMA_ready),
    .ALU_clear(ALU_clear), .ALU_en(ALU_en), .ALU_load(ALU_load), .Bus_datasrc(Bus_datasrc),
    .Neuron_wr(Neuron_wr), .Neuron_layer(Neuron_layer), .Neuron_address(Neuron_address),
`ifdef FC_SOFTMAX_EN
    .softmax_start(softmax_start), .softmax_done(softmax_done),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int cnt; int layer; } dma_t;
  typedef struct { int layer; int n; } wr_t;
  dma_t exp_dma[$];
  wr_t  exp_wr[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  logic en_at_edge = 1'b1;
  logic toggle_mode = 1'b0;
  logic resp_en = 1'b1;
  int wr_cnt = 0, wr_l1_cnt = 0, wr_hi = 0, dma_hi = 0, dma_cnt = 0;
  int first_dma_cyc = -1, first_dma_addr = 0, last_wr_cyc = 0, l0_last_addr = 0;
  dma_t de;
  wr_t  we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(posedge clk) begin
    en_at_edge = clk_en;
    if (clk_en) cyc++;
  end

  initial forever begin
    @(negedge clk);
    clk_en = toggle_mode ? ~clk_en : 1'b1;
  end

  // Monitor: every new strobe (after an enabled edge) is scored once.
  always @(negedge clk) begin
    if (DMA_read) dma_hi++;
    if (Neuron_wr) wr_hi++;
    if (en_at_edge && rst) begin
      if (DMA_read) begin
        dma_cnt++;
        if (first_dma_cyc < 0) begin
          first_dma_cyc  = cyc;
          first_dma_addr = 32'(DMA_address);
        end
        if (exp_dma.size() == 0) chk("dma_unexpected", 32'(1), 32'(0));
        else begin
          de = exp_dma.pop_front();
          chk("dma_addr", 32'(DMA_address), de.addr);
          chk("dma_count", 32'(DMA_count), de.cnt);
          if (de.layer == 0) l0_last_addr = 32'(DMA_address);
        end
      end
      if (Neuron_wr) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (Neuron_layer == 3'd1) wr_l1_cnt++;
        chk("wr_alu_en", 32'(ALU_en), 32'(1));
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'(1), 32'(0));
        else begin
          we = exp_wr.pop_front();
          chk("wr_layer", 32'(Neuron_layer), we.layer);
          chk("wr_addr", 32'(Neuron_address), we.n);
        end
      end
    end
  end

  // DMA slave: ready two cycles after a request, held until an enabled edge takes it.
  initial forever begin
    @(negedge clk);
    if (resp_en && en_at_edge && rst && DMA_read) begin
      repeat (2) @(negedge clk);
      DMA_ready = 1'b1;
      do @(negedge clk); while (!en_at_edge);
      DMA_ready = 1'b0;
    end
  end

`ifdef FC_SOFTMAX_EN
  initial forever begin
    @(negedge clk);
    if (en_at_edge && rst && softmax_start) begin
      repeat (5) @(negedge clk);
      softmax_done = 1'b1;
      sm_set_cyc   = cyc;
      do @(negedge clk); while (!en_at_edge);
      softmax_done = 1'b0;
    end
  end
`endif

  task automatic setup_run(input int in0, input int in1, input int out0, input int out1,
                           input int base0, input int base1, output int n_exp);
    int ins[2], outs[2], bases[2], a;
    ins = '{in0, in1}; outs = '{out0, out1}; bases = '{base0, base1};
    cfg_in_size   = {LAW'(in1), LAW'(in0)};
    cfg_out_size  = {LAW'(out1), LAW'(out0)};
    cfg_base_addr = {MAW'(base1), MAW'(base0)};
    exp_dma.delete();
    exp_wr.delete();
    n_exp = 0;
    for (int l = 0; l < 2; l++) begin
      a = bases[l];
      for (int n = 0; n < outs[l]; n++) begin
        exp_dma.push_back('{a, ins[l] + 1, l});
        exp_wr.push_back('{l, n});
        a = (a + ins[l] + 1) % 1024;
        n_exp++;
      end
    end
    wr_cnt = 0; wr_l1_cnt = 0; wr_hi = 0; dma_hi = 0; dma_cnt = 0; first_dma_cyc = -1;
  endtask

  task automatic run_layers(input int in0, input int in1, input int out0, input int out1,
                            input int base0, input int base1);
    int n_exp, start_cyc, done_cyc, got_done;
    setup_run(in0, in1, out0, out1, base0, base1, n_exp);
    @(negedge clk); #1;
    CNN_ready = 1'b1;
    start_cyc = cyc;
    got_done = 0;
    done_cyc = 0;
    for (int i = 0; i < 4000 && !got_done; i++) begin
      @(negedge clk); #1;
      if (done) begin got_done = 1; done_cyc = cyc; end
    end
    chk("done_seen", 32'(got_done), 32'(1));
    chk("wr_total", 32'(wr_cnt), 32'(n_exp));
    chk("dma_left", 32'(exp_dma.size()), 32'(0));
    chk("wr_left", 32'(exp_wr.size()), 32'(0));
    if (n_exp > 0) chk("first_dma_latency", 32'(first_dma_cyc - start_cyc), 32'(2 + (out0 == 0 ? 1 : 0)));
`ifdef FC_SOFTMAX_EN
    chk("done_after_softmax_done", 32'(done_cyc - sm_set_cyc), 32'(1));
`else
    chk("done_after_last_write", 32'(done_cyc - last_wr_cyc), 32'(2));
`endif
    if (toggle_mode) begin
      chk("wr_pulse_cycles", 32'(wr_hi), 32'(2 * n_exp));
      chk("dma_pulse_cycles", 32'(dma_hi), 32'(2 * n_exp));
    end
    toggle_mode = 1'b0;
    CNN_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("done_cleared", 32'(done), 32'(0));
    chk("bus_idle", 32'(Bus_datasrc), 32'(0));
  endtask

  initial begin
    int n_exp, wr_before, dma_before;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_dma_read", 32'(DMA_read), 32'(0));
    chk("rst_neuron_wr", 32'(Neuron_wr), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_bus", 32'(Bus_datasrc), 32'(0));
    chk("rst_dma_addr", 32'(DMA_address), 32'(0));

    // Baseline two-layer network, including address wrap in layer 0.
    run_layers(120, 84, 84, 10, 1, 'h200);
    chk("l0_84th_addr_wrap", 32'(l0_last_addr), 32'((1 + 83 * 121) % 1024));

    // Empty first layer is skipped entirely.
    run_layers(120, 84, 0, 10, 1, 'h200);
    chk("skip_first_addr", 32'(first_dma_addr), 32'('h200));

    // Bias-only bursts and a full-size input count.
    run_layers(0, 127, 3, 2, 'h3FE, 5);

    // Reset while waiting on a layer-1 burst.
    setup_run(120, 84, 84, 10, 1, 'h200, n_exp);
    @(negedge clk); #1;
    CNN_ready = 1'b1;
    for (int i = 0; i < 4000 && wr_l1_cnt < 3; i++) begin @(negedge clk); #1; end
    chk("reached_layer1", 32'(wr_l1_cnt >= 3), 32'(1));
    resp_en = 1'b0;
    for (int i = 0; i < 20 && !DMA_read; i++) begin @(negedge clk); #1; end
    chk("layer1_req_seen", 32'(DMA_read), 32'(1));
    @(negedge clk);
    CNN_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ctrl_zero", 32'({DMA_read, ALU_clear, ALU_en, ALU_load, Bus_datasrc, Neuron_wr, done}), 32'(0));
    chk("abort_addr_zero", 32'({Neuron_layer, Neuron_address, DMA_count}), 32'(0));
    chk("abort_dma_addr_zero", 32'(DMA_address), 32'(0));
    wr_before = wr_cnt; dma_before = dma_hi;
    DMA_ready = 1'b1;
    @(negedge clk);
    DMA_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("late_ready_no_write", 32'(wr_cnt - wr_before), 32'(0));
    chk("late_ready_no_dma", 32'(dma_hi - dma_before), 32'(0));
    resp_en = 1'b1;
    run_layers(120, 84, 84, 10, 1, 'h200);

    // clk_en toggling every cycle stretches every pulse to two cycles.
    toggle_mode = 1'b1;
    run_layers(120, 84, 84, 10, 1, 'h200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
